mdu: RTL and testbench

Multiply/divide unit that sits beside the ALU in the Execute stage and owns the HI/LO architectural registers. It accepts a start pulse with an operation code and two 32-bit operands. It runs multiplies in 5 cycles and divides in 10 cycles, holding `Busy` high meanwhile so the hazard unit can stall dependent HI/LO instructions. MTHI/MTLO writes complete in a single edge; MFHI/MFLO read the `HI`/`LO` outputs combinationally.

---
 rtl/mdu.sv | 175 +++++++++++++++++
 tb/tb_mdu.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// mdu - multiply/divide unit owning the HI/LO architectural registers.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset, clears all state
//   Start  in   one-cycle request strobe qualifying MDUOp
//   MDUOp  in   0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 no-op
//   A      in   rs operand (multiplicand, dividend, MTHI/MTLO data)
//   B      in   rt operand (multiplier, divisor)
//   Busy   out  high while a multiply/divide is in flight
//   HI     out  HI register
//   LO     out  LO register
//
// The result is computed behaviourally from the operands present at the
// accepting edge and parked in pending registers; the latency counter then
// models the hardware delay before the pending value is committed.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES);
    localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;

    op_e                op;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] divisor;
    logic               div_ovf;
    logic signed [31:0] quot_s, rem_s;
    logic        [31:0] quot_u, rem_u;

    // Arithmetic datapath. A zero divisor is replaced by 1 so the
    // dividers never see it; the commit is suppressed in that case anyway.
    // The INT_MIN / -1 case is pinned explicitly to its wrapped result.
    always_comb begin
        op      = op_e'(MDUOp);
        prod_s  = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u  = {32'b0, A} * {32'b0, B};
        divisor = (B == '0) ? 32'd1 : B;
        div_ovf = (A == 32'h8000_0000) && (B == '1);
        if (div_ovf) begin
            quot_s = $signed(A);
            rem_s  = '0;
        end else begin
            quot_s = $signed(A) / $signed(divisor);
            rem_s  = $signed(A) % $signed(divisor);
        end
        quot_u = A / divisor;
        rem_u  = A % divisor;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    case (op)
                        OP_MULT: begin
                            pend_hi_d = prod_s[63:32];
                            pend_lo_d = prod_s[31:0];
                            pend_wr_d = 1'b1;
                            cnt_d     = MULT_LOAD;
                            state_d   = RUN;
                        end
                        OP_MULTU: begin
                            pend_hi_d = prod_u[63:32];
                            pend_lo_d = prod_u[31:0];
                            pend_wr_d = 1'b1;
                            cnt_d     = MULT_LOAD;
                            state_d   = RUN;
                        end
                        OP_DIV: begin
                            pend_hi_d = rem_s;
                            pend_lo_d = quot_s;
                            pend_wr_d = (B != '0);
                            cnt_d     = DIV_LOAD;
                            state_d   = RUN;
                        end
                        OP_DIVU: begin
                            pend_hi_d = rem_u;
                            pend_lo_d = quot_u;
                            pend_wr_d = (B != '0);
                            cnt_d     = DIV_LOAD;
                            state_d   = RUN;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Start is deliberately ignored here; the hazard unit
                // guarantees nothing is issued while Busy is high.
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign Busy = (state_q == RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu - directed and randomized checks of mdu against an arithmetic
// reference model of the HI/LO registers and operation latencies.
module tb_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    mdu #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .Start(Start),
        .MDUOp(MDUOp),
        .A    (A),
        .B    (B),
        .Busy (Busy),
        .HI   (HI),
        .LO   (LO)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned latency(input logic [2:0] op);
        case (op)
            3'd1, 3'd2: return 5;
            3'd3, 3'd4: return 10;
            default:    return 0;
        endcase
    endfunction

    // Architectural effect of one accepted operation on HI/LO.
    task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, p, q, r;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin
                p = sa * sb;
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            3'd2: begin
                pu = {32'b0, a} * {32'b0, b};
                m_hi = pu[63:32];
                m_lo = pu[31:0];
            end
            3'd3: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            3'd4: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endtask

    // Called at a negedge; issues one op, scrambles the operands after the
    // accepting edge, and returns at the first negedge with Busy low.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        int unsigned cycles;
        Start = 1'b1;
        MDUOp = op;
        A     = a;
        B     = b;
        model_apply(op, a, b);
        @(negedge clk);
        Start  = 1'b0;
        MDUOp  = 3'd0;
        A      = $urandom;
        B      = $urandom;
        cycles = 0;
        while (Busy === 1'b1 && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, 32'(cycles), 32'(latency(op)));
        check({tag, " HI"}, HI, m_hi);
        check({tag, " LO"}, LO, m_lo);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cycles;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        reset = 1'b1;
        Start = 1'b0;
        MDUOp = 3'd0;
        A     = '0;
        B     = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset Busy", {31'b0, Busy}, 32'd0);
        check("reset HI", HI, 32'd0);
        check("reset LO", LO, 32'd0);

        run_op("MULT -2*3", 3'd1, 32'hFFFF_FFFE, 32'h0000_0003);
        check("MULT -2*3 HI const", HI, 32'hFFFF_FFFF);
        check("MULT -2*3 LO const", LO, 32'hFFFF_FFFA);
        run_op("MULTU", 3'd2, 32'hFFFF_FFFE, 32'h0000_0003);
        check("MULTU HI const", HI, 32'h0000_0002);
        check("MULTU LO const", LO, 32'hFFFF_FFFA);

        run_op("DIV -7/2", 3'd3, 32'hFFFF_FFF9, 32'd2);
        check("DIV -7/2 LO const", LO, 32'hFFFF_FFFD);
        check("DIV -7/2 HI const", HI, 32'hFFFF_FFFF);
        run_op("DIVU 7/2", 3'd4, 32'd7, 32'd2);
        check("DIVU 7/2 LO const", LO, 32'd3);
        check("DIVU 7/2 HI const", HI, 32'd1);

        run_op("MTHI", 3'd5, 32'h1234_5678, 32'h0);
        run_op("MTLO", 3'd6, 32'hCAFE_BABE, 32'h0);
        run_op("DIV by 0", 3'd3, 32'h0000_0055, 32'h0);
        check("DIV by 0 HI kept", HI, 32'h1234_5678);
        check("DIV by 0 LO kept", LO, 32'hCAFE_BABE);
        run_op("DIVU by 0", 3'd4, 32'hFFFF_0000, 32'h0);
        run_op("NOP op0", 3'd0, 32'h1111_1111, 32'h2);
        run_op("NOP op7", 3'd7, 32'h2222_2222, 32'h3);

        // MTLO issued during RUN must be ignored; late operand changes too.
        Start = 1'b1;
        MDUOp = 3'd1;
        A     = 32'h0001_0003;
        B     = 32'hFFFF_0005;
        model_apply(3'd1, 32'h0001_0003, 32'hFFFF_0005);
        @(negedge clk);
        Start = 1'b0;
        MDUOp = 3'd0;
        @(negedge clk);
        Start = 1'b1;
        MDUOp = 3'd6;
        A     = 32'h0000_DEAD;
        B     = 32'h0000_FFFA;
        @(negedge clk);
        Start  = 1'b0;
        MDUOp  = 3'd0;
        A      = 32'h5A5A_5A5A;
        cycles = 3;
        while (Busy === 1'b1 && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
        check("MULT ignore-start busy_cycles", 32'(cycles - 1), 32'd5);
        check("MULT ignore-start HI", HI, m_hi);
        check("MULT ignore-start LO", LO, m_lo);

        // Reset during the fourth busy cycle of a divide aborts it.
        Start = 1'b1;
        MDUOp = 3'd3;
        A     = 32'd1000;
        B     = 32'd7;
        @(negedge clk);
        Start = 1'b0;
        MDUOp = 3'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi  = '0;
        m_lo  = '0;
        check("abort Busy", {31'b0, Busy}, 32'd0);
        check("abort HI", HI, 32'd0);
        check("abort LO", LO, 32'd0);
        repeat (15) @(negedge clk);
        check("abort no-commit Busy", {31'b0, Busy}, 32'd0);
        check("abort no-commit HI", HI, 32'd0);
        check("abort no-commit LO", LO, 32'd0);

        // Overflowing divide, then a multiply issued back-to-back.
        run_op("DIV ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("DIV ovf LO const", LO, 32'h8000_0000);
        check("DIV ovf HI const", HI, 32'h0000_0000);
        run_op("MULT b2b", 3'd1, 32'h7FFF_FFFF, 32'h8000_0000);

        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = '1;
                2: ra = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op("random", rop, ra, rb);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
